data_sync_mc: RTL and testbench

- Multi-channel, parametrised bus synchroniser.
- Brings NUM_CH independent asynchronous buses, each qualified by its own enable, into the clk domain.
- Per channel: configurable-depth enable synchroniser, level or toggle event detection, one-cycle enable_pulse, and a valid/ready output holding register.
- Sticky overflow flag and saturating drop counter per channel. Used at every CDC crossing into a register block or FIFO-less consumer.

---
 rtl/data_sync_pkg.sv | 19 +
 rtl/data_sync_mc_if.sv | 28 ++
 rtl/data_sync_chan.sv | 83 ++++++++
 rtl/data_sync_mc.sv | 60 ++++++
 tb/tb_data_sync_mc.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/data_sync_pkg.sv
// rtl/data_sync_pkg.sv - shared constants, types and helpers for the bus synchroniser
package data_sync_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;
  localparam int MIN_CH     = 1;
  localparam int MAX_CH     = 16;

  typedef enum logic {
    EVT_LEVEL  = 1'b0,
    EVT_TOGGLE = 1'b1
  } event_mode_e;

  // Counter stays pinned at max_val once reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_val);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/data_sync_mc_if.sv
// rtl/data_sync_mc_if.sv - source/consumer signal bundle of the multi-channel synchroniser
interface data_sync_mc_if #(
  parameter int NUM_CH     = 4,
  parameter int BUS_WIDTH  = 8,
  parameter int DROP_CNT_W = 4
);

  logic [NUM_CH-1:0]            bus_enable;
  logic [NUM_CH*BUS_WIDTH-1:0]  unsync_bus;
  logic [NUM_CH-1:0]            sync_ready;
  logic                         ovf_clear;
  logic [NUM_CH*BUS_WIDTH-1:0]  sync_bus;
  logic [NUM_CH-1:0]            enable_pulse;
  logic [NUM_CH-1:0]            sync_valid;
  logic [NUM_CH-1:0]            overflow;
  logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output bus_enable, unsync_bus, sync_ready, ovf_clear,
    input  sync_bus, enable_pulse, sync_valid, overflow, drop_cnt
  );

  modport slave (
    input  bus_enable, unsync_bus, sync_ready, ovf_clear,
    output sync_bus, enable_pulse, sync_valid, overflow, drop_cnt
  );

endinterface

// File: rtl/data_sync_chan.sv
// rtl/data_sync_chan.sv - one channel: enable synchroniser, event detect, holding register, overflow tracking
module data_sync_chan
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = 0,
  parameter int DROP_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_enable,
  input  logic [BUS_WIDTH-1:0]  i_data,
  input  logic                  i_ready,
  input  logic                  i_ovf_clear,
  output logic [BUS_WIDTH-1:0]  o_data,
  output logic                  o_pulse,
  output logic                  o_valid,
  output logic                  o_overflow,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  localparam event_mode_e MODE    = event_mode_e'(TOGGLE_MODE);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << DROP_CNT_W) - 64'd1);

  logic [NUM_STAGES-1:0] r_chain;
  logic                  r_hist;
  logic [BUS_WIDTH-1:0]  r_data;
  logic                  r_pulse;
  logic                  r_valid;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  w_event;
  logic                  w_overwrite;

  generate
    if (MODE == EVT_TOGGLE) begin : g_toggle
      assign w_event = r_chain[NUM_STAGES-1] ^ r_hist;
    end else begin : g_level
      assign w_event = r_chain[NUM_STAGES-1] & ~r_hist;
    end
  endgenerate

  // An event landing on unconsumed data loses the older word.
  assign w_overwrite = w_event & r_valid & ~i_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain    <= '0;
      r_hist     <= 1'b0;
      r_data     <= '0;
      r_pulse    <= 1'b0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_chain <= {r_chain[NUM_STAGES-2:0], i_enable};
      r_hist  <= r_chain[NUM_STAGES-1];
      r_pulse <= w_event;
      if (w_event) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      if (w_overwrite) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= i_ovf_clear ? DROP_CNT_W'(1)
                                  : DROP_CNT_W'(sat_inc(32'(r_drop_cnt), CNT_MAX));
      end else if (i_ovf_clear) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  assign o_data     = r_data;
  assign o_pulse    = r_pulse;
  assign o_valid    = r_valid;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/data_sync_mc.sv
// rtl/data_sync_mc.sv - multi-channel asynchronous bus synchroniser top
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 4,
  parameter int TOGGLE_MODE = 0,
  parameter int DROP_CNT_W  = 4
) (
  input logic          clk,
  input logic          reset_n,
  data_sync_mc_if.slave bus
);

  generate
    if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
      $error("data_sync_mc: NUM_STAGES must be within 2..4");
    end
    if (NUM_CH < MIN_CH || NUM_CH > MAX_CH) begin : g_bad_ch
      $error("data_sync_mc: NUM_CH must be within 1..16");
    end
  endgenerate

  logic [NUM_CH*BUS_WIDTH-1:0]  w_sync_bus;
  logic [NUM_CH-1:0]            w_pulse;
  logic [NUM_CH-1:0]            w_valid;
  logic [NUM_CH-1:0]            w_overflow;
  logic [NUM_CH*DROP_CNT_W-1:0] w_drop_cnt;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      data_sync_chan #(
        .NUM_STAGES (NUM_STAGES),
        .BUS_WIDTH  (BUS_WIDTH),
        .TOGGLE_MODE(TOGGLE_MODE),
        .DROP_CNT_W (DROP_CNT_W)
      ) u_chan (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_enable   (bus.bus_enable[g]),
        .i_data     (bus.unsync_bus[g*BUS_WIDTH +: BUS_WIDTH]),
        .i_ready    (bus.sync_ready[g]),
        .i_ovf_clear(bus.ovf_clear),
        .o_data     (w_sync_bus[g*BUS_WIDTH +: BUS_WIDTH]),
        .o_pulse    (w_pulse[g]),
        .o_valid    (w_valid[g]),
        .o_overflow (w_overflow[g]),
        .o_drop_cnt (w_drop_cnt[g*DROP_CNT_W +: DROP_CNT_W])
      );
    end
  endgenerate

  assign bus.sync_bus     = w_sync_bus;
  assign bus.enable_pulse = w_pulse;
  assign bus.sync_valid   = w_valid;
  assign bus.overflow     = w_overflow;
  assign bus.drop_cnt     = w_drop_cnt;

endmodule

// File: tb/tb_data_sync_mc.sv
// tb/tb_data_sync_mc.sv - directed self-checking bench for data_sync_mc
module tb_data_sync_mc;

  logic clk = 1'b0;
  logic reset_n;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  data_sync_mc_if #(.NUM_CH(4), .BUS_WIDTH(8),  .DROP_CNT_W(4)) if_a ();
  data_sync_mc_if #(.NUM_CH(4), .BUS_WIDTH(8),  .DROP_CNT_W(4)) if_b ();
  data_sync_mc_if #(.NUM_CH(1), .BUS_WIDTH(16), .DROP_CNT_W(4)) if_c ();

  data_sync_mc #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .TOGGLE_MODE(0), .DROP_CNT_W(4))
    u_dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  data_sync_mc #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .TOGGLE_MODE(1), .DROP_CNT_W(4))
    u_dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  data_sync_mc #(.NUM_STAGES(3), .BUS_WIDTH(16), .NUM_CH(1), .TOGGLE_MODE(0), .DROP_CNT_W(4))
    u_dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] seen_pulse;

  initial begin
    reset_n = 1'b0;
    if_a.bus_enable = '0; if_a.unsync_bus = '0; if_a.sync_ready = 4'b1101; if_a.ovf_clear = 1'b0;
    if_b.bus_enable = '0; if_b.unsync_bus = '0; if_b.sync_ready = 4'b1111; if_b.ovf_clear = 1'b0;
    if_c.bus_enable = '0; if_c.unsync_bus = '0; if_c.sync_ready = 1'b1;    if_c.ovf_clear = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("rst_sync_bus", 64'(if_a.sync_bus), 64'h0);
    chk("rst_pulse",    64'(if_a.enable_pulse), 64'h0);
    chk("rst_valid",    64'(if_a.sync_valid), 64'h0);
    chk("rst_ovf",      64'(if_a.overflow), 64'h0);
    chk("rst_drop",     64'(if_a.drop_cnt), 64'h0);

    // ch0 level word with consumer ready
    if_a.unsync_bus = 32'h0000_00A5;
    tick();
    if_a.bus_enable = 4'b0001;
    tick(2);
    chk("ch0_no_early_pulse", 64'(if_a.enable_pulse), 64'h0);
    tick();
    chk("ch0_pulse",   64'(if_a.enable_pulse), 64'h1);
    chk("ch0_bus",     64'(if_a.sync_bus), 64'h0000_00A5);
    chk("ch0_valid",   64'(if_a.sync_valid), 64'h1);
    tick();
    chk("ch0_pulse_w", 64'(if_a.enable_pulse), 64'h0);
    chk("ch0_consume", 64'(if_a.sync_valid), 64'h0);
    chk("ch0_hold",    64'(if_a.sync_bus), 64'h0000_00A5);
    if_a.bus_enable = 4'b0000;
    tick(3);

    // ch1 two words with consumer stalled
    if_a.unsync_bus = 32'h0000_11A5;
    tick();
    if_a.bus_enable = 4'b0010;
    tick(3);
    chk("ch1_w1_pulse", 64'(if_a.enable_pulse), 64'h2);
    chk("ch1_w1_ovf",   64'(if_a.overflow), 64'h0);
    if_a.bus_enable = 4'b0000;
    tick(3);
    if_a.unsync_bus = 32'h0000_22A5;
    tick();
    if_a.bus_enable = 4'b0010;
    tick(3);
    chk("ch1_w2_pulse", 64'(if_a.enable_pulse), 64'h2);
    chk("ch1_w2_bus",   64'(if_a.sync_bus), 64'h0000_22A5);
    chk("ch1_w2_ovf",   64'(if_a.overflow), 64'h2);
    chk("ch1_w2_drop",  64'(if_a.drop_cnt), 64'h0010);
    chk("ch1_w2_valid", 64'(if_a.sync_valid), 64'h2);
    if_a.bus_enable = 4'b0000;
    if_a.sync_ready = 4'b1111;
    tick();
    chk("ch1_consume",  64'(if_a.sync_valid), 64'h0);
    chk("ch1_ovf_stky", 64'(if_a.overflow), 64'h2);
    if_a.sync_ready = 4'b0111;
    tick(2);

    // ch3: 21 words, 20 overwrites, counter saturates at 15
    for (int k = 0; k < 21; k++) begin
      if_a.unsync_bus[31:24] = 8'(k + 1);
      tick();
      if_a.bus_enable[3] = 1'b1;
      tick(3);
      if_a.bus_enable[3] = 1'b0;
      tick(3);
    end
    chk("sat_drop",  64'(if_a.drop_cnt), 64'hF010);
    chk("sat_ovf",   64'(if_a.overflow), 64'hA);
    chk("sat_bus",   64'(if_a.sync_bus), 64'h1500_22A5);
    chk("sat_valid", 64'(if_a.sync_valid), 64'h8);

    // clear coinciding with an overwrite on ch3: set wins
    if_a.unsync_bus[31:24] = 8'h77;
    tick();
    if_a.bus_enable[3] = 1'b1;
    tick(2);
    if_a.ovf_clear = 1'b1;
    tick();
    if_a.ovf_clear = 1'b0;
    chk("clr_set_pulse", 64'(if_a.enable_pulse), 64'h8);
    chk("clr_set_ovf",   64'(if_a.overflow), 64'h8);
    chk("clr_set_drop",  64'(if_a.drop_cnt), 64'h1000);
    chk("clr_set_bus",   64'(if_a.sync_bus), 64'h7700_22A5);
    if_a.bus_enable[3] = 1'b0;
    tick(3);
    if_a.ovf_clear = 1'b1;
    tick();
    if_a.ovf_clear = 1'b0;
    chk("clr_ovf",  64'(if_a.overflow), 64'h0);
    chk("clr_drop", 64'(if_a.drop_cnt), 64'h0);

    // all four channels in the same cycle
    if_a.sync_ready = 4'b1111;
    tick();
    chk("all_pre_valid", 64'(if_a.sync_valid), 64'h0);
    if_a.unsync_bus = 32'hC3C2_C1C0;
    tick();
    if_a.bus_enable = 4'b1111;
    tick(3);
    chk("all_pulse", 64'(if_a.enable_pulse), 64'hF);
    chk("all_bus",   64'(if_a.sync_bus), 64'hC3C2_C1C0);
    chk("all_valid", 64'(if_a.sync_valid), 64'hF);
    chk("all_ovf",   64'(if_a.overflow), 64'h0);
    tick();
    chk("all_pulse_w", 64'(if_a.enable_pulse), 64'h0);
    chk("all_consume", 64'(if_a.sync_valid), 64'h0);
    if_a.bus_enable = 4'b0000;
    tick(3);

    // toggle protocol on ch2
    for (int k = 0; k < 3; k++) begin
      if_b.unsync_bus[23:16] = 8'(k + 1);
      tick();
      if_b.bus_enable[2] = ~if_b.bus_enable[2];
      tick(3);
      chk($sformatf("tgl%0d_pulse", k), 64'(if_b.enable_pulse), 64'h4);
      chk($sformatf("tgl%0d_bus", k),   64'(if_b.sync_bus), 64'(32'(k + 1) << 16));
      tick();
      chk($sformatf("tgl%0d_pulse_w", k), 64'(if_b.enable_pulse), 64'h0);
      tick(2);
    end
    chk("tgl_ovf",  64'(if_b.overflow), 64'h0);
    chk("tgl_drop", 64'(if_b.drop_cnt), 64'h0);

    // three-stage, 16-bit channel
    if_c.unsync_bus = 16'hBEEF;
    tick();
    if_c.bus_enable = 1'b1;
    tick(3);
    chk("st3_no_early", 64'(if_c.enable_pulse), 64'h0);
    tick();
    chk("st3_pulse", 64'(if_c.enable_pulse), 64'h1);
    chk("st3_bus",   64'(if_c.sync_bus), 64'hBEEF);
    if_c.bus_enable = 1'b0;

    // asynchronous reset while a word is mid-synchronisation
    if_a.unsync_bus = 32'h5A5A_5A5A;
    tick();
    if_a.bus_enable = 4'b1111;
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst_bus",   64'(if_a.sync_bus), 64'h0);
    chk("arst_pulse", 64'(if_a.enable_pulse), 64'h0);
    chk("arst_valid", 64'(if_a.sync_valid), 64'h0);
    chk("arst_c_bus", 64'(if_c.sync_bus), 64'h0);
    if_a.bus_enable = 4'b0000;
    tick();
    reset_n = 1'b1;
    seen_pulse = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen_pulse = seen_pulse | if_a.enable_pulse;
    end
    chk("arst_no_pulse", 64'(seen_pulse), 64'h0);
    chk("arst_bus_post", 64'(if_a.sync_bus), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
